// File: rtl/jstk_pkg.sv
// Shared definitions for the joystick SPI responder: frame size, command flag
// position, FSM state encoding and the order of bytes in a response frame.
package jstk_pkg;

  localparam int NUM_BYTES_DEF = 5;
  localparam int CMD_FLAG_BIT  = 7;

  localparam int BYTE_X_LO = 0;
  localparam int BYTE_X_HI = 1;
  localparam int BYTE_Y_LO = 2;
  localparam int BYTE_Y_HI = 3;
  localparam int BYTE_BTN  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Byte idx of a response frame built from a position/button snapshot.
  // Indices outside the defined frame read as zero.
  function automatic logic [7:0] frame_byte(input logic [9:0] x,
                                            input logic [9:0] y,
                                            input logic [2:0] b,
                                            input int         idx);
    logic [7:0] val;
    case (idx)
      BYTE_X_LO: val = x[7:0];
      BYTE_X_HI: val = {6'b000000, x[9:8]};
      BYTE_Y_LO: val = y[7:0];
      BYTE_Y_HI: val = {6'b000000, y[9:8]};
      BYTE_BTN:  val = {5'b00000, b};
      default:   val = 8'h00;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input followed by a single-cycle
// rise/fall detector working on the synchronized level.
module sync_edge_det #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_r;
  logic              prev_r;

  // Shift the raw input through the synchronizer chain and remember the last level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= {STAGES{RESET_VAL}};
      prev_r <= RESET_VAL;
    end else begin
      sync_r <= (sync_r << 1) | STAGES'(din);
      prev_r <= sync_r[STAGES-1];
    end
  end

  assign level = sync_r[STAGES-1];
  assign rise  = level & ~prev_r;
  assign fall  = ~level & prev_r;

endmodule

// File: rtl/jstk_spi_responder.sv
// SPI mode-0 responder that emulates a joystick module: streams a snapshot of
// X/Y/buttons to the master and takes LED bits from the first command byte.
module jstk_spi_responder
  import jstk_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_BYTES   = NUM_BYTES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       CS,
  input  logic       SCLK,
  input  logic       MOSI,
  output logic       MISO,
  input  logic [9:0] X_in,
  input  logic [9:0] Y_in,
  input  logic [2:0] Buttons_in,
  output logic [1:0] Led_out,
  output logic       Frame_done,
  output logic       Frame_err
);

  localparam int BCW = $clog2(NUM_BYTES + 1);

  logic cs_level_s,   cs_rise_s,   cs_fall_s;
  logic sclk_level_s, sclk_rise_s, sclk_fall_s;
  logic mosi_level_s, mosi_rise_s, mosi_fall_s;
  logic unused_s;

  state_t           state_r, state_s;
  logic [9:0]       x_r, x_s;
  logic [9:0]       y_r, y_s;
  logic [2:0]       btn_r, btn_s;
  logic [2:0]       bit_cnt_r, bit_cnt_s;
  logic [BCW-1:0]   byte_cnt_r, byte_cnt_s;
  logic [7:0]       rx_r, rx_s, rx_next_s;
  logic             miso_r, miso_s;
  logic [1:0]       led_r, led_s;
  logic             done_r, done_s;
  logic             err_r, err_s;

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .reset(reset), .din(CS),
    .level(cs_level_s), .rise(cs_rise_s), .fall(cs_fall_s)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .reset(reset), .din(SCLK),
    .level(sclk_level_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .reset(reset), .din(MOSI),
    .level(mosi_level_s), .rise(mosi_rise_s), .fall(mosi_fall_s)
  );

  assign unused_s = ^{sclk_level_s, mosi_rise_s, mosi_fall_s};

  // Bit to present on MISO for a given position; bytes past the frame read zero.
  function automatic logic tx_bit(input logic [BCW-1:0] byte_idx,
                                  input logic [2:0]     bit_idx,
                                  input logic [9:0]     x,
                                  input logic [9:0]     y,
                                  input logic [2:0]     b);
    logic [7:0] cur;
    cur = frame_byte(x, y, b, int'(byte_idx));
    if (byte_idx >= BCW'(NUM_BYTES)) begin
      return 1'b0;
    end else begin
      return cur[~bit_idx];
    end
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      x_r        <= 10'd0;
      y_r        <= 10'd0;
      btn_r      <= 3'd0;
      bit_cnt_r  <= 3'd0;
      byte_cnt_r <= '0;
      rx_r       <= 8'h00;
      miso_r     <= 1'b0;
      led_r      <= 2'b00;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      x_r        <= x_s;
      y_r        <= y_s;
      btn_r      <= btn_s;
      bit_cnt_r  <= bit_cnt_s;
      byte_cnt_r <= byte_cnt_s;
      rx_r       <= rx_s;
      miso_r     <= miso_s;
      led_r      <= led_s;
      done_r     <= done_s;
      err_r      <= err_s;
    end
  end

  // Next-state and next-value logic for the frame FSM.
  always_comb begin
    state_s    = state_r;
    x_s        = x_r;
    y_s        = y_r;
    btn_s      = btn_r;
    bit_cnt_s  = bit_cnt_r;
    byte_cnt_s = byte_cnt_r;
    rx_s       = rx_r;
    rx_next_s  = {rx_r[6:0], mosi_level_s};
    miso_s     = miso_r;
    led_s      = led_r;
    done_s     = 1'b0;
    err_s      = 1'b0;

    case (state_r)
      IDLE: begin
        miso_s     = 1'b0;
        bit_cnt_s  = 3'd0;
        byte_cnt_s = '0;
        if (cs_fall_s) begin
          // Snapshot the inputs and present the first bit straight away.
          state_s = SHIFT;
          x_s     = X_in;
          y_s     = Y_in;
          btn_s   = Buttons_in;
          miso_s  = tx_bit('0, 3'd0, X_in, Y_in, Buttons_in);
        end else begin
          state_s = IDLE;
        end
      end

      SHIFT: begin
        if (cs_rise_s) begin
          state_s    = IDLE;
          miso_s     = 1'b0;
          bit_cnt_s  = 3'd0;
          byte_cnt_s = '0;
          if ((bit_cnt_r == 3'd0) && (byte_cnt_r >= BCW'(NUM_BYTES))) begin
            done_s = 1'b1;
          end else begin
            err_s = 1'b1;
          end
        end else if (!cs_level_s && sclk_rise_s) begin
          rx_s      = rx_next_s;
          bit_cnt_s = bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
            // Only the first byte carries a command; later bytes are ignored.
            if ((byte_cnt_r == '0) && rx_next_s[CMD_FLAG_BIT]) begin
              led_s = rx_next_s[1:0];
            end else begin
              led_s = led_r;
            end
            if (byte_cnt_r < BCW'(NUM_BYTES)) begin
              byte_cnt_s = byte_cnt_r + BCW'(1);
            end else begin
              byte_cnt_s = byte_cnt_r;
            end
          end else begin
            byte_cnt_s = byte_cnt_r;
          end
        end else if (!cs_level_s && sclk_fall_s) begin
          miso_s = tx_bit(byte_cnt_r, bit_cnt_r, x_r, y_r, btn_r);
        end else begin
          miso_s = miso_r;
        end
      end

      default: begin
        state_s = IDLE;
        miso_s  = 1'b0;
      end
    endcase
  end

  assign MISO       = miso_r;
  assign Led_out    = led_r;
  assign Frame_done = done_r;
  assign Frame_err  = err_r;

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Self-checking bench for jstk_spi_responder: a bit-banged SPI master at
// SCLK = clk/10, expected frame bytes queued per frame and checked on receipt.
module tb_jstk_spi_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       CS = 1'b1;
  logic       SCLK = 1'b0;
  logic       MOSI = 1'b0;
  logic       MISO;
  logic [9:0] X_in = 10'd0;
  logic [9:0] Y_in = 10'd0;
  logic [2:0] Buttons_in = 3'd0;
  logic [1:0] Led_out;
  logic       Frame_done;
  logic       Frame_err;

  int n_vec = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] b;
    logic [7:0] m0;
    int         nbits;
    logic [1:0] led;
    logic       done;
    logic       err;
  } vec_t;

  vec_t vt[7];

  jstk_spi_responder dut (
    .clk(clk), .reset(reset), .CS(CS), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .X_in(X_in), .Y_in(Y_in), .Buttons_in(Buttons_in), .Led_out(Led_out),
    .Frame_done(Frame_done), .Frame_err(Frame_err)
  );

  always #5 clk = ~clk;

  // Count completion / abort pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (Frame_done) done_cnt++;
    if (Frame_err) err_cnt++;
  end

  function automatic logic [7:0] model_byte(input logic [9:0] x, input logic [9:0] y,
                                            input logic [2:0] b, input int k);
    case (k)
      0: return x[7:0];
      1: return {6'b000000, x[9:8]};
      2: return y[7:0];
      3: return {6'b000000, y[9:8]};
      4: return {5'b00000, b};
      default: return 8'h00;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input logic [9:0] x, input logic [9:0] y, input logic [2:0] b,
                           input logic [7:0] m0, input int nbits, input int chg_bit,
                           input int rst_bit, input logic [1:0] exp_led,
                           input logic exp_done, input logic exp_err, input string tag);
    int d0;
    int e0;
    logic [7:0] rx;
    logic [7:0] exp_b;
    rx = 8'h00;
    @(negedge clk);
    X_in = x;
    Y_in = y;
    Buttons_in = b;
    for (int k = 0; k < nbits / 8; k++) exp_q.push_back(model_byte(x, y, b, k));
    d0 = done_cnt;
    e0 = err_cnt;
    CS = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_bit) begin
        reset = 1'b1;
        CS = 1'b1;
        SCLK = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        break;
      end
      if (i == chg_bit) X_in = 10'h3FF;
      MOSI = (i < 8) ? m0[7 - i] : 1'($urandom);
      repeat (5) @(negedge clk);
      rx = {rx[6:0], MISO};
      SCLK = 1'b1;
      repeat (5) @(negedge clk);
      SCLK = 1'b0;
      if ((i % 8) == 7) begin
        if (exp_q.size() == 0) begin
          check($sformatf("%s queue_empty_byte%0d", tag, i / 8), 32'd1, 32'd0);
        end else begin
          exp_b = exp_q.pop_front();
          check($sformatf("%s byte%0d", tag, i / 8), {24'd0, rx}, {24'd0, exp_b});
        end
      end
    end
    repeat (5) @(negedge clk);
    CS = 1'b1;
    repeat (8) @(negedge clk);
    check({tag, " done_pulses"}, done_cnt - d0, {31'd0, exp_done});
    check({tag, " err_pulses"}, err_cnt - e0, {31'd0, exp_err});
    check({tag, " led"}, {30'd0, Led_out}, {30'd0, exp_led});
    check({tag, " miso_idle"}, {31'd0, MISO}, 32'd0);
  endtask

  initial begin
    vt[0] = '{10'h2A5, 10'h13C, 3'b101, 8'h00, 40, 2'b00, 1'b1, 1'b0};
    vt[1] = '{10'h3FF, 10'h000, 3'b010, 8'b10000001, 40, 2'b01, 1'b1, 1'b0};
    vt[2] = '{10'h155, 10'h2AA, 3'b111, 8'b00000011, 40, 2'b01, 1'b1, 1'b0};
    vt[3] = '{10'h001, 10'h002, 3'b001, 8'b10000010, 13, 2'b10, 1'b0, 1'b1};
    vt[4] = '{10'h0AB, 10'h3CD, 3'b011, 8'h00, 56, 2'b10, 1'b1, 1'b0};
    vt[5] = '{10'h123, 10'h321, 3'b100, 8'hFF, 3, 2'b10, 1'b0, 1'b1};
    vt[6] = '{10'h200, 10'h100, 3'b110, 8'h80, 41, 2'b00, 1'b0, 1'b1};

    repeat (4) @(negedge clk);
    check("reset miso", {31'd0, MISO}, 32'd0);
    check("reset led", {30'd0, Led_out}, 32'd0);
    check("reset done", {31'd0, Frame_done}, 32'd0);
    check("reset err", {31'd0, Frame_err}, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      run_frame(vt[v].x, vt[v].y, vt[v].b, vt[v].m0, vt[v].nbits, -1, -1,
                vt[v].led, vt[v].done, vt[v].err, $sformatf("vec%0d", v));
    end

    // Input change mid-frame must not disturb the snapshot; next frame sees it.
    run_frame(10'h2A5, 10'h13C, 3'b101, 8'h00, 40, 12, -1, 2'b00, 1'b1, 1'b0, "snap_hold");
    check("snap_hold x_changed", {22'd0, X_in}, 32'h3FF);
    run_frame(10'h3FF, 10'h13C, 3'b101, 8'h00, 40, -1, -1, 2'b00, 1'b1, 1'b0, "snap_next");

    // Reset in the middle of a frame: no abort pulse, outputs back to reset values.
    run_frame(10'h2A5, 10'h13C, 3'b101, 8'h83, 40, -1, -1, 2'b11, 1'b1, 1'b0, "pre_reset");
    run_frame(10'h2A5, 10'h13C, 3'b101, 8'h00, 40, -1, 20, 2'b00, 1'b0, 1'b0, "mid_reset");
    run_frame(10'h2A5, 10'h13C, 3'b101, 8'h00, 40, -1, -1, 2'b00, 1'b1, 1'b0, "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
